// File: rtl/sliscp_perm_ctrl.sv
// sLiSCP-light permutation controller: sequences NUM_STEPS calls of an external step datapath.
// Optional cycle counter output perf_cycles is built when SLISCP_PERF_CNT_EN is defined.
module sliscp_perm_ctrl #(
    parameter int unsigned WIDTH     = 48,
    parameter int unsigned NUM_STEPS = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*WIDTH-1:0]   state_in,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [4*WIDTH-1:0]   state_out,
    output logic [4*WIDTH-1:0]   step_sin,
    output logic                 step_en_rnd_ctr,
    input  logic                 step_rnd_done,
    input  logic [4*WIDTH-1:0]   step_sout,
    output logic [7:0]           rc0,
    output logic [7:0]           rc1,
    output logic [7:0]           sc0,
    output logic [7:0]           sc1,
    output logic [4:0]           step_idx
`ifdef SLISCP_PERF_CNT_EN
    ,
    output logic [15:0]          perf_cycles
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    localparam logic [4:0] LP_LAST = 5'(NUM_STEPS - 1);

    fsm_t                 r_fsm;
    fsm_t                 w_fsm_nxt;
    logic [4*WIDTH-1:0]   r_state;
    logic [4:0]           r_step_idx;
    logic                 w_capture;
    logic                 w_step_load;
    logic                 w_idx_inc;
    logic [31:0]          w_rom;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt       = r_fsm;
        w_capture       = 1'b0;
        w_step_load     = 1'b0;
        w_idx_inc       = 1'b0;
        ready           = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        step_en_rnd_ctr = 1'b0;
        unique case (r_fsm)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_capture = 1'b1;
                    w_fsm_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy            = 1'b1;
                step_en_rnd_ctr = 1'b1;
                if (step_rnd_done) begin
                    w_step_load = 1'b1;
                    if (r_step_idx == LP_LAST) begin
                        w_fsm_nxt = S_DONE;
                    end else begin
                        w_idx_inc = 1'b1;
                    end
                end
            end
            S_DONE: begin
                done      = 1'b1;
                w_fsm_nxt = S_IDLE;
            end
            default: begin
                w_fsm_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= '0;
            r_step_idx <= '0;
        end else if (w_capture) begin
            r_state    <= state_in;
            r_step_idx <= '0;
        end else if (w_step_load) begin
            r_state <= step_sout;
            if (w_idx_inc) begin
                r_step_idx <= r_step_idx + 5'd1;
            end
        end
    end

    // Entries are {rc0, rc1, sc0, sc1}; all constants are 6-bit values.
    always_comb begin
        w_rom = '0;
        case (r_step_idx)
            5'd0:  w_rom = 32'h07_27_08_29;
            5'd1:  w_rom = 32'h04_34_0c_1d;
            5'd2:  w_rom = 32'h06_2e_0a_33;
            5'd3:  w_rom = 32'h25_19_2f_2a;
            5'd4:  w_rom = 32'h17_35_38_1f;
            5'd5:  w_rom = 32'h1c_0f_24_10;
            5'd6:  w_rom = 32'h12_08_36_18;
            5'd7:  w_rom = 32'h3b_0c_0d_14;
            5'd8:  w_rom = 32'h26_0a_2b_1e;
            5'd9:  w_rom = 32'h15_2f_3e_31;
            5'd10: w_rom = 32'h3f_38_01_09;
            5'd11: w_rom = 32'h20_24_21_2d;
            5'd12: w_rom = 32'h30_36_11_1b;
            5'd13: w_rom = 32'h28_0d_39_3f;
            5'd14: w_rom = 32'h3c_2b_05_3c;
            5'd15: w_rom = 32'h22_3e_27_26;
            5'd16: w_rom = 32'h13_01_1d_12;
            5'd17: w_rom = 32'h1a_21_3d_2d;
            default: w_rom = '0;
        endcase
        if (r_step_idx > LP_LAST) begin
            w_rom = '0;
        end
    end

    assign rc0       = {2'b00, w_rom[29:24]};
    assign rc1       = {2'b00, w_rom[21:16]};
    assign sc0       = {2'b00, w_rom[13:8]};
    assign sc1       = {2'b00, w_rom[5:0]};
    assign state_out = r_state;
    assign step_sin  = r_state;
    assign step_idx  = r_step_idx;

`ifdef SLISCP_PERF_CNT_EN
    logic [15:0] r_perf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf <= '0;
        end else if (w_capture) begin
            r_perf <= '0;
        end else if (busy && (r_perf != '1)) begin
            r_perf <= r_perf + 16'd1;
        end
    end

    assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_sliscp_perm_ctrl.sv
// Scoreboard bench for sliscp_perm_ctrl with a behavioural step datapath (done every 6th enabled cycle).
module tb_sliscp_perm_ctrl;

    localparam int unsigned W = 48;
    localparam int unsigned S = 4 * W;
    localparam int unsigned STEPS = 18;
    localparam int unsigned CYC_PER_STEP = 6;
    localparam int LAT = STEPS * CYC_PER_STEP + 2;

    localparam logic [31:0] TBL [18] = '{
        32'h07_27_08_29, 32'h04_34_0c_1d, 32'h06_2e_0a_33, 32'h25_19_2f_2a,
        32'h17_35_38_1f, 32'h1c_0f_24_10, 32'h12_08_36_18, 32'h3b_0c_0d_14,
        32'h26_0a_2b_1e, 32'h15_2f_3e_31, 32'h3f_38_01_09, 32'h20_24_21_2d,
        32'h30_36_11_1b, 32'h28_0d_39_3f, 32'h3c_2b_05_3c, 32'h22_3e_27_26,
        32'h13_01_1d_12, 32'h1a_21_3d_2d
    };

    logic           clk;
    logic           rst;
    logic           start;
    logic [S-1:0]   state_in;
    logic           ready;
    logic           busy;
    logic           done;
    logic [S-1:0]   state_out;
    logic [S-1:0]   step_sin;
    logic           step_en_rnd_ctr;
    logic           step_rnd_done;
    logic [S-1:0]   step_sout;
    logic [7:0]     rc0, rc1, sc0, sc1;
    logic [4:0]     step_idx;
`ifdef SLISCP_PERF_CNT_EN
    logic [15:0]    perf_cycles;
`endif

    sliscp_perm_ctrl #(.WIDTH(W), .NUM_STEPS(STEPS)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .state_in        (state_in),
        .ready           (ready),
        .busy            (busy),
        .done            (done),
        .state_out       (state_out),
        .step_sin        (step_sin),
        .step_en_rnd_ctr (step_en_rnd_ctr),
        .step_rnd_done   (step_rnd_done),
        .step_sout       (step_sout),
        .rc0             (rc0),
        .rc1             (rc1),
        .sc0             (sc0),
        .sc1             (sc1),
        .step_idx        (step_idx)
`ifdef SLISCP_PERF_CNT_EN
        ,
        .perf_cycles     (perf_cycles)
`endif
    );

    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    int           done_cnt = 0;
    bit           force_done = 0;
    logic [S-1:0] sb_q [$];
    logic [S-1:0] last_exp = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [S-1:0] act, input logic [S-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [S-1:0] mix(input logic [S-1:0] s, input int unsigned k);
        logic [31:0] c;
        c = TBL[k];
        return {s[S-8:0], s[S-1:S-7]} ^ {6{c}} ^ S'(k + 1);
    endfunction

    function automatic logic [S-1:0] model_perm(input logic [S-1:0] v);
        logic [S-1:0] e;
        e = v;
        for (int unsigned k = 0; k < STEPS; k++) e = mix(e, k);
        return e;
    endfunction

    // Behavioural step datapath: drives its outputs mid-cycle for the next rising edge.
    initial begin : step_model
        int unsigned ecnt;
        int unsigned k;
        ecnt = 0;
        forever begin
            @(negedge clk);
            if (rst || !step_en_rnd_ctr) begin
                ecnt          = 0;
                step_rnd_done = force_done;
                step_sout     = ~step_sin;
            end else begin
                ecnt++;
                if (ecnt % CYC_PER_STEP == 0) begin
                    k = ecnt / CYC_PER_STEP - 1;
                    if (k < STEPS) begin
                        check("step_idx", S'(step_idx), S'(k));
                        check("consts", S'({rc0, rc1, sc0, sc1}), S'(TBL[k]));
                        step_sout = mix(step_sin, k);
                    end else begin
                        check("step_overrun", S'(k), S'(STEPS - 1));
                        step_sout = ~step_sin;
                    end
                    step_rnd_done = 1'b1;
                end else begin
                    step_rnd_done = 1'b0;
                    step_sout     = ~step_sin;
                end
            end
        end
    end

    initial begin : sb_monitor
        logic [S-1:0] e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_done", S'(1), S'(0));
                end else begin
                    e = sb_q.pop_front();
                    last_exp = e;
                    check("state_out_done", state_out, e);
                end
            end
        end
    end

    task automatic start_perm(input logic [S-1:0] v, input bit hold, output int s);
        @(negedge clk);
        check("ready_at_start", S'(ready), S'(1));
        state_in = v;
        start    = 1'b1;
        s        = cyc;
        sb_q.push_back(model_perm(v));
        if (!hold) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic wait_done(input int s);
        bit seen;
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            check("done_timeout", S'(0), S'(1));
        end else begin
            check("latency", S'(cyc - s + 1), S'(LAT));
`ifdef SLISCP_PERF_CNT_EN
            check("perf_cycles", S'(perf_cycles), S'(STEPS * CYC_PER_STEP));
`endif
        end
    endtask

    function automatic logic [S-1:0] rnd192();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin : main
        int           s;
        int           d0;
        bit           hit;
        logic [S-1:0] v;
        logic [S-1:0] exp0;

        rst = 1'b1; start = 1'b0; state_in = '0;
        step_rnd_done = 1'b0; step_sout = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", S'(ready), S'(1));
        check("rst_busy", S'(busy), S'(0));
        check("rst_done", S'(done), S'(0));
        check("rst_en", S'(step_en_rnd_ctr), S'(0));
        check("rst_state", state_out, '0);
        check("rst_idx", S'(step_idx), S'(0));
        rst = 1'b0;

        // Zero input, latency and hold-after-done
        exp0 = model_perm('0);
        start_perm('0, 0, s);
        check("busy_run", S'(busy), S'(1));
        wait_done(s);
        @(negedge clk);
        check("done_one_cycle", S'(done), S'(0));
        repeat (3) @(negedge clk);
        check("hold_after_done", state_out, exp0);

        // step_rnd_done high while idle must be ignored
        force_done = 1;
        repeat (4) @(negedge clk);
        check("idle_en", S'(step_en_rnd_ctr), S'(0));
        check("idle_state", state_out, exp0);
        check("idle_ready", S'(ready), S'(1));
        force_done = 0;
        @(negedge clk);

        // Random inputs
        for (int i = 0; i < 2; i++) begin
            start_perm(rnd192(), 0, s);
            wait_done(s);
        end

        // Start and new state_in during RUN are ignored
        start_perm(rnd192(), 0, s);
        repeat (20) @(negedge clk);
        state_in = rnd192();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(s);

        // Start held across the whole run, then re-sampled right after done
        v  = rnd192();
        d0 = done_cnt;
        start_perm(v, 1, s);
        wait_done(s);
        @(negedge clk);
        check("single_done", S'(done_cnt - d0), S'(1));
        check("ready_after_done", S'(ready), S'(1));
        s = cyc;
        sb_q.push_back(model_perm(v));
        @(negedge clk);
        start = 1'b0;
        check("restart_busy", S'(busy), S'(1));
        wait_done(s);

        // Reset mid-run at step 9
        start_perm(rnd192(), 0, s);
        hit = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (step_idx == 5'd9) begin
                hit = 1;
                break;
            end
        end
        check("reach_step9", S'(hit), S'(1));
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        check("abort_ready", S'(ready), S'(1));
        check("abort_busy", S'(busy), S'(0));
        check("abort_en", S'(step_en_rnd_ctr), S'(0));
        check("abort_state", state_out, '0);
        check("abort_idx", S'(step_idx), S'(0));
`ifdef SLISCP_PERF_CNT_EN
        check("abort_perf", S'(perf_cycles), S'(0));
`endif
        @(negedge clk);
        rst = 1'b0;
        void'(sb_q.pop_back());
        repeat (120) @(negedge clk);
        check("abort_no_done", S'(done_cnt - d0), S'(0));
        start_perm(rnd192(), 0, s);
        wait_done(s);

        repeat (2) @(negedge clk);
        check("sb_drained", S'(sb_q.size()), S'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
